fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: none; reset PC SHALL be `START_OF_MEM, and widths SHALL use `BITS32 from riscv.vh.
REQ-002 clk  input  1  single clock for all state; rising-edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 imem_addr  output  32  byte address presented to instruction memory; equals PC register.
REQ-005 imem_instr  input  32  instruction word returned combinationally by memory for imem_addr, same cycle.
REQ-006 redirect_valid  input  1  branch/jump redirect request from execute.
REQ-007 redirect_pc  input  32  redirect target byte address.
REQ-008 halt_req  input  1  stop fetching after current cycle.
REQ-009 dec_valid  output  1  head entry valid toward decode.
REQ-010 dec_ready  input  1  decode accepts head entry.
REQ-011 dec_instr  output  32  head entry instruction.
REQ-012 dec_pc  output  32  head entry PC.
REQ-013 fetch_misaligned  output  1  sticky misaligned-redirect flag.

Function
REQ-014 The block SHALL hold a PC register and a 2-entry FIFO of {pc, instr}; dec_valid = (count != 0); dec_instr/dec_pc = head entry.
REQ-015 States SHALL be: HOLD (first cycle after reset release, no fetch), RUN, HALTED; HOLD->RUN unconditionally after one cycle.
REQ-016 Enqueue in RUN: when no redirect and (count < 2 or a dequeue occurs this cycle), {pc, imem_instr} SHALL be written and pc <= pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-017 Dequeue: dec_valid && dec_ready SHALL pop the head; simultaneous enqueue and dequeue SHALL keep count unchanged.
REQ-018 Redirect (highest priority, any state): FIFO SHALL be cleared, pc <= redirect_pc, no enqueue that cycle, state -> RUN; a same-cycle decode handshake SHALL count as completed.
REQ-019 First redirected instruction SHALL appear on dec_valid exactly 1 cycle after the redirect cycle.
REQ-020 halt_req in RUN (no redirect) SHALL move state to HALTED; the enqueue that cycle still occurs; HALTED SHALL not enqueue but SHALL keep draining the FIFO.
REQ-021 Throughput: with dec_ready held high in RUN, one instruction per cycle SHALL be delivered.
REQ-022 dec_instr/dec_pc SHALL remain stable while dec_valid && !dec_ready.

Reset
REQ-023 On reset: pc = `START_OF_MEM, count = 0, dec_valid = 0, dec_instr = 0, dec_pc = 0, fetch_misaligned = 0, state = HOLD.
REQ-024 Reset asserted mid-operation SHALL discard all FIFO contents immediately (asynchronously).

Configuration
REQ-025 Macro FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0] != 0 SHALL set fetch_misaligned (sticky until reset), clear FIFO, load pc = redirect_pc & ~3, and enter HALTED.
REQ-026 Macro FETCH_MISALIGN_CHECK_EN undefined: redirect_pc[1:0] SHALL be silently forced to 0, state -> RUN, and fetch_misaligned SHALL be tied 0.

Verification (bench with `START_OF_MEM = 0x00000000)
REQ-027 Reset release, dec_ready=1 -> imem_addr 0x0 in HOLD; dec_valid first high 2 cycles after release with dec_pc 0x0, then 0x4, 0x8 on consecutive cycles.
REQ-028 dec_ready=0 for 5 cycles -> count saturates at 2, imem_addr stalls at 0x8, dec_pc held at 0x0; dec_ready=1 -> 0x0, 0x4, 0x8 delivered back-to-back.
REQ-029 redirect_valid with redirect_pc 0x100 while FIFO full -> next cycle dec_valid=1, dec_pc=0x100; old entries 0x4/0x8 never delivered.
REQ-030 halt_req at pc 0x10 -> entry 0x10 delivered, no 0x14; redirect to 0x40 -> fetching resumes at 0x40.
REQ-031 pc loaded 0xFFFFFFFC via redirect -> next dec_pc sequence 0xFFFFFFFC, 0x00000000.
REQ-032 With FETCH_MISALIGN_CHECK_EN, redirect_pc 0x102 -> fetch_misaligned=1, state HALTED, dec_valid=0; without the macro -> dec_pc 0x100, fetch_misaligned=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC register feeding a 2-entry {pc, instr} queue toward decode.
// Optional feature macro FETCH_MISALIGN_CHECK_EN: misaligned redirects halt fetch and raise a sticky flag.

`ifndef BITS32
`define BITS32 [31:0]
`endif
`ifndef START_OF_MEM
`define START_OF_MEM 32'h0000_0000
`endif

module fetch_unit (
  input  logic         clk,
  input  logic         reset,
  output logic `BITS32 imem_addr,
  input  logic `BITS32 imem_instr,
  input  logic         redirect_valid,
  input  logic `BITS32 redirect_pc,
  input  logic         halt_req,
  output logic         dec_valid,
  input  logic         dec_ready,
  output logic `BITS32 dec_instr,
  output logic `BITS32 dec_pc,
  output logic         fetch_misaligned
);

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic `BITS32 pc, pc_nxt;
  logic `BITS32 q_pc    [2];
  logic `BITS32 q_instr [2];
  logic         rd_ptr, wr_ptr;
  logic [1:0]   count;
  logic         enq, deq, misalign;

  function automatic logic `BITS32 word_align(input logic `BITS32 addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  assign deq       = dec_valid && dec_ready;
  assign imem_addr = pc;
  assign dec_valid = (count != 2'd0);
  assign dec_pc    = q_pc[rd_ptr];
  assign dec_instr = q_instr[rd_ptr];

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_misaligned <= 1'b0;
    end else if (misalign) begin
      fetch_misaligned <= 1'b1;
    end
  end
`else
  assign misalign         = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

  // Next-state: a redirect overrides everything, including a pending halt.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    enq       = 1'b0;
    if (redirect_valid) begin
      pc_nxt    = word_align(redirect_pc);
      state_nxt = misalign ? HALTED : RUN;
    end else begin
      unique case (state)
        HOLD: state_nxt = RUN;
        RUN: begin
          if ((count < 2'd2) || deq) begin
            enq    = 1'b1;
            pc_nxt = pc + 32'd4;
          end
          if (halt_req) begin
            state_nxt = HALTED;
          end
        end
        HALTED: state_nxt = HALTED;
        default: state_nxt = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HOLD;
      pc    <= `START_OF_MEM;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Fetch -> decode queue boundary; entries cleared on reset so decode sees zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (redirect_valid) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (enq) begin
        q_pc[wr_ptr]    <= pc;
        q_instr[wr_ptr] <= imem_instr;
        wr_ptr          <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized redirect/halt/ready traffic
// compared against a queue-based model of the fetch unit.

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        fetch_misaligned;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_hold;
  bit          m_halted;
  bit          m_mis;

  fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .imem_addr        (imem_addr),
    .imem_instr       (imem_instr),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .halt_req         (halt_req),
    .dec_valid        (dec_valid),
    .dec_ready        (dec_ready),
    .dec_instr        (dec_instr),
    .dec_pc           (dec_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc     = 32'h0000_0000;
    m_hold   = 1'b1;
    m_halted = 1'b0;
    m_mis    = 1'b0;
  endtask

  // Behaviour of one clock edge, from the inputs held across that edge.
  task automatic model_step();
    ent_t e;
    if (redirect_valid) begin
      m_q.delete();
      m_pc     = redirect_pc & 32'hFFFF_FFFC;
      m_hold   = 1'b0;
      m_halted = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        m_mis    = 1'b1;
        m_halted = 1'b1;
      end
`endif
    end else begin
      if (m_q.size() != 0 && dec_ready) void'(m_q.pop_front());
      if (m_hold) begin
        m_hold = 1'b0;
      end else if (!m_halted) begin
        if (m_q.size() < 2) begin
          e.pc    = m_pc;
          e.instr = mem_word(m_pc);
          m_q.push_back(e);
          m_pc = m_pc + 32'd4;
        end
        if (halt_req) m_halted = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    chk("dec_valid", dec_valid, m_q.size() != 0);
    chk("imem_addr", imem_addr, m_pc);
    chk("fetch_misaligned", fetch_misaligned, m_mis);
    if (m_q.size() != 0) begin
      chk("dec_pc", dec_pc, m_q[0].pc);
      chk("dec_instr", dec_instr, m_q[0].instr);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    reset          = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", dec_valid, 1'b0);
    chk("rst_pc", dec_pc, 32'h0);
    chk("rst_instr", dec_instr, 32'h0);
    chk("rst_mis", fetch_misaligned, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Start-up latency and streaming
    dec_ready = 1'b1;
    cycle();
    cycle();
    chk("first_valid", dec_valid, 1'b1);
    chk("first_pc", dec_pc, 32'h0);
    cycle();
    chk("seq_pc4", dec_pc, 32'h4);
    cycle();
    chk("seq_pc8", dec_pc, 32'h8);

    // Backpressure then drain
    do_reset();
    dec_ready = 1'b0;
    repeat (5) cycle();
    chk("stall_addr", imem_addr, 32'h8);
    chk("stall_pc", dec_pc, 32'h0);
    dec_ready = 1'b1;
    chk("drain_pc0", dec_pc, 32'h0);
    cycle();
    chk("drain_pc4", dec_pc, 32'h4);
    cycle();
    chk("drain_pc8", dec_pc, 32'h8);

    // Redirect while full
    dec_ready = 1'b0;
    redirect(32'h100);
    chk("redir_flush", dec_valid, 1'b0);
    chk("redir_addr", imem_addr, 32'h100);
    dec_ready = 1'b1;
    cycle();
    chk("redir_valid", dec_valid, 1'b1);
    chk("redir_pc", dec_pc, 32'h100);
    cycle();
    chk("redir_pc2", dec_pc, 32'h104);

    // Halt, drain, resume by redirect
    redirect(32'h10);
    halt_req = 1'b1;
    cycle();
    halt_req = 1'b0;
    chk("halt_pc", dec_pc, 32'h10);
    cycle();
    chk("halt_empty", dec_valid, 1'b0);
    cycle();
    chk("halt_stay", dec_valid, 1'b0);
    chk("halt_addr", imem_addr, 32'h14);
    redirect(32'h40);
    cycle();
    chk("resume_pc", dec_pc, 32'h40);

    // PC wrap
    redirect(32'hFFFF_FFFC);
    cycle();
    chk("wrap_pc0", dec_pc, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_pc1", dec_pc, 32'h0);

    // Misaligned redirect
    redirect(32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_flag", fetch_misaligned, 1'b1);
    chk("mis_valid", dec_valid, 1'b0);
    cycle();
    cycle();
    chk("mis_halted", dec_valid, 1'b0);
    chk("mis_addr", imem_addr, 32'h100);
    redirect(32'h200);
    cycle();
    chk("mis_sticky", fetch_misaligned, 1'b1);
    chk("mis_resume", dec_pc, 32'h200);
`else
    cycle();
    chk("align_pc", dec_pc, 32'h100);
    chk("align_flag", fetch_misaligned, 1'b0);
`endif

    // Randomized traffic
    repeat (400) begin
      dec_ready      = ($urandom_range(0, 9) < 7);
      halt_req       = ($urandom_range(0, 39) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom();
      if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
      cycle();
    end
    redirect_valid = 1'b0;
    halt_req       = 1'b0;

    // Asynchronous reset with a full queue
    dec_ready = 1'b0;
    redirect(32'h80);
    cycle();
    cycle();
    chk("pre_rst_valid", dec_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", dec_valid, 1'b0);
    chk("async_addr", imem_addr, 32'h0);
    chk("async_pc", dec_pc, 32'h0);
    chk("async_mis", fetch_misaligned, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    dec_ready = 1'b1;
    repeat (10) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
